// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared state encodings and constant helpers for input_conditioner
package input_cond_pkg;
  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous 1-bit input
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronize, debounce and edge-detect a raw input, counting accepted rises
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_ovf
);
  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic s;
  logic rise_evt;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s)
  );
  // rise_evt marks the edge on which rise, and the event counter, are updated
  assign rise_evt = (state == CHK_HI) && s && (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LO;
      cnt     <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      evt_cnt <= '0;
      evt_ovf <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: if (s) begin
          state <= CHK_HI;
          cnt   <= CW'(1);
        end
        CHK_HI: if (!s) begin
          state <= ST_LO;
          cnt   <= '0;
        end else if (cnt == LAST) begin
          state <= ST_HI;
          dout  <= 1'b1;
          rise  <= 1'b1;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        ST_HI: if (!s) begin
          state <= CHK_LO;
          cnt   <= CW'(1);
        end
        CHK_LO: if (s) begin
          state <= ST_HI;
          cnt   <= '0;
        end else if (cnt == LAST) begin
          state <= ST_LO;
          dout  <= 1'b0;
          fall  <= 1'b1;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= ST_LO;
      endcase
      if (clr_cnt) begin
        evt_cnt <= rise_evt ? CNT_W'(1) : '0;
        evt_ovf <= 1'b0;
      end else if (rise_evt) begin
        evt_cnt <= evt_cnt + 1'b1;
        evt_ovf <= evt_ovf | (&evt_cnt);
      end
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks on a small-counter instance plus a bounce run against a reference model
module tb_input_conditioner;
  import input_cond_pkg::*;
  localparam int S1 = 3;
  localparam int D1 = 8;
  logic clk = 0;
  logic rst = 1;
  logic din0 = 0, din1 = 0, clr = 0;
  logic dout0, rise0, fall0, ovf0;
  logic [3:0] cnt0;
  logic dout1, rise1, fall1, ovf1;
  logic [7:0] cnt1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .din(din0), .clr_cnt(clr),
    .dout(dout0), .rise(rise0), .fall(fall0), .evt_cnt(cnt0), .evt_ovf(ovf0)
  );
  input_conditioner #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .din(din1), .clr_cnt(1'b0),
    .dout(dout1), .rise(rise1), .fall(fall1), .evt_cnt(cnt1), .evt_ovf(ovf1)
  );
  // reference for u1: delay line, then count consecutive samples that disagree with the level
  logic [S1-1:0] m_sh;
  logic m_dout, m_rise, m_fall;
  int m_run;
  always @(posedge clk) begin
    if (rst) begin
      m_sh = '0; m_dout = 0; m_rise = 0; m_fall = 0; m_run = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (m_sh[S1-1] != m_dout) begin
        m_run++;
        if (m_run == D1) begin
          m_dout = ~m_dout;
          m_rise = m_dout;
          m_fall = ~m_dout;
          m_run = 0;
        end
      end else m_run = 0;
      m_sh = {m_sh[S1-2:0], din1};
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] exp_cnt, input logic exp_ovf);
    din0 = 1;
    repeat (5) tick();
    check("press_pre", dout0, 0);
    tick();
    check("press_rise", rise0, 1);
    check("press_cnt", cnt0, exp_cnt);
    check("press_ovf", ovf0, exp_ovf);
    din0 = 0;
    repeat (6) tick();
    check("release_fall", fall0, 1);
    tick();
  endtask
  initial begin
    repeat (2) tick();
    check("rst_dout", dout0, 0);
    check("rst_rise", rise0, 0);
    check("rst_fall", fall0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_ovf", ovf0, 0);
    rst = 0;
    din0 = 1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("lat_dout_lo", dout0, 0);
      check("lat_rise_lo", rise0, 0);
    end
    tick();
    check("lat_dout", dout0, 1);
    check("lat_rise", rise0, 1);
    check("lat_cnt", cnt0, 1);
    tick();
    check("rise_once", rise0, 0);
    check("dout_hold", dout0, 1);
    din0 = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("fall_dout_hi", dout0, 1);
      check("fall_pre", fall0, 0);
    end
    tick();
    check("fall_pulse", fall0, 1);
    check("fall_dout", dout0, 0);
    check("fall_cnt", cnt0, 1);
    tick();
    check("fall_once", fall0, 0);
    din0 = 1;
    repeat (3) tick();
    din0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_dout", dout0, 0);
      check("glitch_pulse", rise0 | fall0, 0);
    end
    check("glitch_cnt", cnt0, 1);
    check("glitch_state", u0.state, ST_LO);
    for (int i = 2; i <= 15; i++) press(4'(i), 0);
    press(4'd0, 1);
    press(4'd1, 1);
    clr = 1;
    tick();
    clr = 0;
    check("clr_cnt", cnt0, 0);
    check("clr_ovf", ovf0, 0);
    check("clr_dout", dout0, 0);
    din0 = 1;
    repeat (5) tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr_rise", rise0, 1);
    check("clr_rise_cnt", cnt0, 1);
    din0 = 0;
    repeat (8) tick();
    din0 = 1;
    repeat (3) tick();
    check("mid_state", u0.state, CHK_HI);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_out", {dout0, rise0, fall0, ovf0, cnt0}, 0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("mid_no_rise", rise0, 0);
    end
    tick();
    check("mid_rise", rise0, 1);
    check("mid_cnt", cnt0, 1);
    begin
      int last = -1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 97 == 0) din1 = ~din1;
        else if ($urandom_range(0, 9) < 2) din1 = ~din1;
        if (cyc % 400 > 300) din1 = cyc[9];
        tick();
        check("rnd_dout", dout1, m_dout);
        check("rnd_rise", rise1, m_rise);
        check("rnd_fall", fall1, m_fall);
        check("rnd_both", rise1 & fall1, 0);
        if (rise1 | fall1) begin
          if (last >= 0) check("rnd_spacing", (cyc - last) >= D1, 1);
          last = cyc;
        end
      end
      check("rnd_toggled", last >= 0, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
